// File: rtl/bubble_sort_ctrl.sv
// Serial bubble-sort controller: load DEPTH words, sort in place with one shared compare-and-swap per clock, stream out ascending.
// Optional macro EARLY_EXIT_EN: finish sorting after the first pass that performs no swap.
module bubble_sort_ctrl #(
  parameter int N     = 7,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_last,
  output logic         busy,
  output logic         done,
  output logic [1:0]   state_dbg
);

  localparam int IW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [IW-1:0] LAST_IDX  = IW'(DEPTH - 1);
  localparam logic [IW-1:0] LAST_PASS = IW'(DEPTH - 2);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_SORT  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  mem [DEPTH];
  logic [IW-1:0] wr_idx, rd_idx, j, p;
  logic [IW-1:0] j_next, j_last;
  logic          in_fire, out_fire, pass_end, do_swap, sort_exit, done_r;

  // Handshakes: a word moves only in a cycle where valid and ready are both high.
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign j_next   = j + 1'b1;
  assign j_last   = LAST_PASS - p;
  assign pass_end = (j == j_last);
  assign do_swap  = (state == S_SORT) && (mem[j] > mem[j_next]);

`ifdef EARLY_EXIT_EN
  logic swapped;
  // A pass with no swap (including this compare) proves the buffer is sorted.
  assign sort_exit = pass_end && ((p == LAST_PASS) || !(swapped || do_swap));
`else
  assign sort_exit = pass_end && (p == LAST_PASS);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_LOAD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_LOAD:  if (in_fire && (wr_idx == LAST_IDX)) state_nxt = S_SORT;
      S_SORT:  if (sort_exit) state_nxt = S_DRAIN;
      S_DRAIN: if (out_fire && (rd_idx == LAST_IDX)) state_nxt = S_LOAD;
      default: state_nxt = S_LOAD;
    endcase
  end

  always_comb begin
    in_ready  = (state == S_LOAD);
    out_valid = (state == S_DRAIN);
    out_data  = out_valid ? mem[rd_idx] : '0;
    out_last  = out_valid && (rd_idx == LAST_IDX);
    busy      = (state == S_SORT) || (state == S_DRAIN);
    done      = done_r;
    state_dbg = state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_idx <= '0;
      rd_idx <= '0;
      j      <= '0;
      p      <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= out_fire && out_last;
      case (state)
        S_LOAD: begin
          if (in_fire) begin
            mem[wr_idx] <= in_data;
            wr_idx      <= (wr_idx == LAST_IDX) ? '0 : wr_idx + 1'b1;
          end
        end
        S_SORT: begin
          if (do_swap) begin
            mem[j]      <= mem[j_next];
            mem[j_next] <= mem[j];
          end
          if (pass_end) begin
            j <= '0;
            p <= sort_exit ? '0 : p + 1'b1;
          end else begin
            j <= j_next;
          end
        end
        S_DRAIN: begin
          if (out_fire) rd_idx <= (rd_idx == LAST_IDX) ? '0 : rd_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef EARLY_EXIT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          swapped <= 1'b0;
    else if (state != S_SORT)         swapped <= 1'b0;
    else if (pass_end)                swapped <= 1'b0;
    else if (do_swap)                 swapped <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_bubble_sort_ctrl.sv
// Self-checking bench for bubble_sort_ctrl (DEPTH=4, N=7): directed table, corner sequences, random frames.
module tb_bubble_sort_ctrl;
  localparam int N = 7;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] out_data;
  logic         out_last;
  logic         busy;
  logic         done;
  logic [1:0]   state_dbg;

  int total  = 0;
  int passed = 0;
  logic [N-1:0] exp_q[$];

  typedef logic [D-1:0][N-1:0] frame_t;
  typedef struct packed {
    frame_t     din;
    frame_t     dout;
    logic [7:0] sort_cyc;
  } vec_t;

  bubble_sort_ctrl #(.N(N), .DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s actual=%0d required=%0d", name, act, req);
  endtask

  function automatic frame_t mk(input int a, input int b, input int c, input int d);
    frame_t f;
    f[0] = N'(a); f[1] = N'(b); f[2] = N'(c); f[3] = N'(d);
    return f;
  endfunction

  // Reference: stable ascending order by rank counting.
  function automatic frame_t model_sort(input frame_t f);
    frame_t s;
    int rank;
    s = '0;
    for (int i = 0; i < D; i++) begin
      rank = 0;
      for (int k = 0; k < D; k++)
        if (f[k] < f[i] || (f[k] == f[i] && k < i)) rank++;
      s[rank] = f[i];
    end
    return s;
  endfunction

  // Reference sort latency; with early exit, passes needed = max count of larger words ahead of any word, plus one.
  function automatic int model_cycles(input frame_t f);
    int cyc;
`ifdef EARLY_EXIT_EN
    int maxd, dcnt, passes;
    maxd = 0;
    for (int i = 0; i < D; i++) begin
      dcnt = 0;
      for (int k = 0; k < i; k++) if (f[k] > f[i]) dcnt++;
      if (dcnt > maxd) maxd = dcnt;
    end
    passes = (maxd + 1 < D - 1) ? maxd + 1 : D - 1;
    cyc = 0;
    for (int q = 0; q < passes; q++) cyc += D - 1 - q;
`else
    cyc = D * (D - 1) / 2;
`endif
    return cyc;
  endfunction

  task automatic load_words(input frame_t f);
    for (int i = 0; i < D; i++) begin
      @(negedge clk);
      chk("in_ready_load", in_ready, 1);
      in_valid = 1'b1;
      in_data  = f[i];
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_frame(input frame_t f, input frame_t exp_out, input int exp_cyc,
                           input logic [15:0] pat, input bit use_pat, input bit hold);
    int sc, guard, words, k;
    bit stalled, leak;
    logic [N-1:0] held;
    for (int i = 0; i < D; i++) exp_q.push_back(exp_out[i]);
    load_words(f);
    in_valid = hold;
    in_data  = N'($urandom_range(0, 127));
    sc = 0; guard = 0; leak = 0;
    while (!out_valid && guard < 200) begin
      if (busy) sc++;
      if (in_ready) leak = 1;
      @(negedge clk);
      if (hold) in_data = N'($urandom_range(0, 127));
      guard++;
    end
    chk("sort_cycles", sc, exp_cyc);
    words = 0; k = 0; stalled = 0; guard = 0; held = '0;
    while (words < D && guard < 200) begin
      if (stalled) chk("held_data", out_data, held);
      chk("out_valid", out_valid, 1);
      chk("out_last", out_last, (words == D - 1) ? 1 : 0);
      if (in_ready) leak = 1;
      out_ready = use_pat ? pat[k % 16] : 1'b1;
      k++;
      if (out_ready) begin
        chk("out_data", out_data, exp_q.pop_front());
        words++;
        stalled = 0;
        if (words == D) in_valid = 1'b0;
      end else begin
        stalled = 1;
        held    = out_data;
      end
      @(negedge clk);
      if (hold && words < D) in_data = N'($urandom_range(0, 127));
      guard++;
    end
    if (guard >= 200) chk("drain_timeout", words, D);
    out_ready = 1'b0;
    chk("done_pulse", done, 1);
    chk("in_ready_after", in_ready, 1);
    chk("busy_after", busy, 0);
    chk("no_accept_busy", leak, 0);
    @(negedge clk);
    chk("done_clear", done, 0);
  endtask

  task automatic check_reset_outputs();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_state", state_dbg, 0);
  endtask

  vec_t vecs[4];
  int   sorted_cyc;

  initial begin
    frame_t f;
`ifdef EARLY_EXIT_EN
    sorted_cyc = 3;
`else
    sorted_cyc = 6;
`endif
    vecs[0] = '{din: mk(40, 30, 20, 10),  dout: mk(10, 20, 30, 40),  sort_cyc: 8'd6};
    vecs[1] = '{din: mk(1, 2, 3, 4),      dout: mk(1, 2, 3, 4),      sort_cyc: 8'(sorted_cyc)};
    vecs[2] = '{din: mk(127, 0, 127, 0),  dout: mk(0, 0, 127, 127),  sort_cyc: 8'd6};
    vecs[3] = '{din: mk(3, 1, 2, 0),      dout: mk(0, 1, 2, 3),      sort_cyc: 8'd6};

    // Reset held with in_valid high: nothing may be taken.
    in_valid = 1'b1;
    in_data  = 7'd99;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    in_valid = 1'b0;
    rst = 1'b0;

    foreach (vecs[i]) run_frame(vecs[i].din, vecs[i].dout, vecs[i].sort_cyc, 16'h0, 1'b0, 1'b0);

    // Backpressure during drain: ready pattern 1,0,0,1,0,1,1.
    run_frame(mk(40, 30, 20, 10), mk(10, 20, 30, 40), 6, 16'h0069, 1'b1, 1'b0);

    // in_valid held through sort/drain, then a fresh frame must load from slot 0.
    run_frame(mk(5, 9, 1, 7), mk(1, 5, 7, 9), 6, 16'h0, 1'b0, 1'b1);
    run_frame(mk(2, 2, 1, 0), mk(0, 1, 2, 2), 6, 16'h0, 1'b0, 1'b0);

    // Reset after the second compare of a sort.
    load_words(mk(40, 30, 20, 10));
    chk("busy_in_sort", busy, 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst = 1'b0;
    run_frame(mk(3, 1, 2, 0), mk(0, 1, 2, 3), 6, 16'h0, 1'b0, 1'b0);

    // Random frames against the reference model, with random drain backpressure.
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < D; i++)
        f[i] = (r % 3 == 0) ? N'($urandom_range(0, 3)) : N'($urandom_range(0, 127));
      if (r % 5 == 1) f = model_sort(f);
      run_frame(f, model_sort(f), model_cycles(f), 16'($urandom) | 16'h0001, (r % 2) == 1, (r % 4) == 2);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/bubble_sort_ctrl.md
# bubble_sort_ctrl

Sequencing controller for a serial bubble sort over a small register buffer. It accepts DEPTH words through a valid/ready input stream and sorts them in place. One shared compare-and-swap step runs per clock, in bubble-sort pass order. It then streams the words out in ascending order on a valid/ready output with a last marker. It is the serial, area-lean counterpart to the fully unrolled swapper-chain sorters, for use where one comparator must be time-shared across a whole frame.

## Interface
- N, default 7: data word width in bits, unsigned.
- DEPTH, default 4: words per frame, at least 2. Internal counters are $clog2(DEPTH) bits, minimum 1.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input word present.
- in_ready  output  1  controller can accept a word.
- in_data  input  N  input word.
- out_valid  output  1  sorted word present.
- out_ready  input  1  downstream accepts the word.
- out_data  output  N  sorted word.
- out_last  output  1  marks the final word of the frame.
- busy  output  1  high in SORT and DRAIN.
- done  output  1  one-cycle pulse after the last output handshake.

## Operation
- States:
  - LOAD: in_ready=1. Each in_valid&&in_ready writes buf[wr_idx] and increments wr_idx. The DEPTH-th accept moves to SORT and clears wr_idx.
  - SORT: one compare per cycle on the pair (buf[j], buf[j+1]).
    - Swap only if buf[j] > buf[j+1], strictly and unsigned, so equal words never move and order is stable.
    - j runs 0..DEPTH-2-p for pass p, with p = 0..DEPTH-2.
    - At the end of a pass, j resets to 0 and p increments.
    - After the compare of the final pass (p=DEPTH-2, j=0), move to DRAIN.
  - DRAIN: out_valid=1 and out_data=buf[rd_idx]. out_last=1 when rd_idx==DEPTH-1. Each out_valid&&out_ready increments rd_idx. The handshake on the last word pulses done for the next cycle and moves to LOAD with all indices cleared.
- in_ready=0 in SORT and DRAIN. in_valid is ignored there and no data is consumed.
- out_data is held stable while out_valid&&!out_ready.
- The swap flag per pass is set by any swap in that pass and is cleared at each pass start.

## Timing
- Reset values (held while rst=1): state=LOAD, in_ready=1, out_valid=0, out_data=0, out_last=0, busy=0, done=0. All indices are 0 and buf contents are 0.
- No input is accepted while rst=1.
- Reset asserted mid-frame, in any state, discards the frame. LOAD with in_ready=1 resumes on the first clock edge after release.
- Load: one word per cycle at full rate. The cycle after the DEPTH-th accept is the first SORT compare.
- Sort latency without early exit is always DEPTH*(DEPTH-1)/2 cycles (6 for DEPTH=4). The swap result is visible in buf on the next edge.
- The first output is valid the cycle after the last SORT compare.
- Drain: one word per cycle when out_ready=1. done is high in the cycle following the last handshake, the same cycle in which in_ready returns to 1.
- Minimum frame period for DEPTH=4 without early exit: 4 load + 6 sort + 4 drain = 14 cycles.

## Configuration
- EARLY_EXIT_EN defined:
  - At the end of any pass with no swap, go directly to DRAIN and skip the remaining passes.
  - Already-sorted input takes DEPTH-1 sort cycles (3 for DEPTH=4).
- EARLY_EXIT_EN undefined:
  - The swap flag is not built.
  - Sort latency is fixed at DEPTH*(DEPTH-1)/2 cycles for every input.

## Test plan
- Reverse frame, DEPTH=4, N=7: load 40,30,20,10 with out_ready=1 → out 10,20,30,40, out_last on 40, done one cycle later. Exactly 6 busy SORT cycles.
- Sorted frame 1,2,3,4: with EARLY_EXIT_EN → 3 SORT cycles; without it → 6 SORT cycles. Output is 1,2,3,4 in both cases.
- Duplicates and extremes 127,0,127,0 → out 0,0,127,127. No swap occurs between equal words.
- Backpressure: toggle out_ready 1,0,0,1,0,1,1 during DRAIN → out_data is held while stalled, each word appears exactly once in order, and out_last is high only with the final word.
- in_valid held high through SORT and DRAIN with changing in_data → no extra word accepted. The next frame loads starting at buf[0] after done.
- Reset mid-SORT after the 2nd compare → all outputs at their reset values and state LOAD. A fresh frame 3,1,2,0 afterwards sorts to 0,1,2,3.
